input_conditioner: RTL and testbench

Conditions the raw push-button inputs for the game logic. Each button is synchronized, debounced, edge-detected and, where enabled, auto-repeated using delayed auto shift. The block emits one-cycle action pulses to the game-state logic. It also emits a single `state_update` strobe whenever any action fires; the latency metrics handler downstream uses that strobe to start its input-to-V_SYNC measurement.

---
 rtl/input_conditioner.sv | 162 ++++++++++++++++
 tb/tb_input_conditioner.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// input_conditioner: per-key synchronizer, debouncer, press detector and
// delayed-auto-shift repeater. It emits registered one-cycle action pulses
// and a combined state_update strobe, both gated by enable.
module input_conditioner #(
    parameter int unsigned       N_KEYS          = 5,
    parameter int unsigned       DEBOUNCE_CYCLES = 50000,
    parameter int unsigned       DAS_CYCLES      = 8000000,
    parameter int unsigned       ARR_CYCLES      = 2500000,
    parameter logic [N_KEYS-1:0] REPEAT_MASK     = 5'b00111
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_n,
    input  logic              enable,
    output logic [N_KEYS-1:0] action,
    output logic [N_KEYS-1:0] held,
    output logic              state_update
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TMAX   = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
    localparam int unsigned TM_W   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    logic [N_KEYS-1:0] events;
    logic [N_KEYS-1:0] action_q;
    logic              state_update_q;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        logic            s1_q;
        logic            s2_q;
        logic            held_q;
        logic            held_d;
        logic            held_dly_q;
        logic [DB_W-1:0] db_cnt_q;
        logic [DB_W-1:0] db_cnt_d;
        state_t          st_q;
        state_t          st_d;
        logic [TM_W-1:0] tmr_q;
        logic [TM_W-1:0] tmr_d;
        logic            ev;
        logic            rise;

        // Two-flop synchronizer on the inverted (active-high) button level.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1_q <= 1'b0;
                s2_q <= 1'b0;
            end else begin
                s1_q <= ~key_n[i];
                s2_q <= s1_q;
            end
        end

        // Debounce: count consecutive mismatch cycles, accept the new level on the last one.
        always_comb begin
            held_d   = held_q;
            db_cnt_d = '0;
            if (s2_q != held_q) begin
                if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    held_d = s2_q;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
        end

        // Debounce state and a delayed copy of held used for press detection.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                held_q     <= 1'b0;
                held_dly_q <= 1'b0;
                db_cnt_q   <= '0;
            end else begin
                held_q     <= held_d;
                held_dly_q <= held_q;
                db_cnt_q   <= db_cnt_d;
            end
        end

        assign rise = held_q & ~held_dly_q;

        // Repeat FSM next state: press event, DAS delay, then ARR repeats; release wins over a due repeat.
        always_comb begin
            st_d  = st_q;
            tmr_d = tmr_q;
            ev    = 1'b0;
            case (st_q)
                IDLE: begin
                    tmr_d = '0;
                    if (rise) begin
                        ev = 1'b1;
                        if (REPEAT_MASK[i]) begin
                            st_d = DELAY;
                        end
                    end
                end
                DELAY: begin
                    if (!held_q) begin
                        st_d  = IDLE;
                        tmr_d = '0;
                    end else if (tmr_q == TM_W'(DAS_CYCLES - 1)) begin
                        ev    = 1'b1;
                        tmr_d = '0;
                        st_d  = REPEAT;
                    end else begin
                        tmr_d = tmr_q + TM_W'(1);
                    end
                end
                REPEAT: begin
                    if (!held_q) begin
                        st_d  = IDLE;
                        tmr_d = '0;
                    end else if (tmr_q == TM_W'(ARR_CYCLES - 1)) begin
                        ev    = 1'b1;
                        tmr_d = '0;
                    end else begin
                        tmr_d = tmr_q + TM_W'(1);
                    end
                end
                default: begin
                    st_d  = IDLE;
                    tmr_d = '0;
                end
            endcase
        end

        // Repeat FSM state and timer registers.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                st_q  <= IDLE;
                tmr_q <= '0;
            end else begin
                st_q  <= st_d;
                tmr_q <= tmr_d;
            end
        end

        assign events[i] = ev;
        assign held[i]   = held_q;
    end

    // Register the enable-gated action pulses and the combined strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            action_q       <= '0;
            state_update_q <= 1'b0;
        end else begin
            action_q       <= events & {N_KEYS{enable}};
            state_update_q <= (|events) & enable;
        end
    end

    assign action       = action_q;
    assign state_update = state_update_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with short debounce/DAS/ARR timings.
module tb_input_conditioner;

    localparam int unsigned NK = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [NK-1:0] key_n;
    logic [NK-1:0] action;
    logic [NK-1:0] held;
    logic          state_update;

    int unsigned errors = 0;
    int unsigned checks = 0;

    input_conditioner #(
        .N_KEYS         (5),
        .DEBOUNCE_CYCLES(4),
        .DAS_CYCLES     (10),
        .ARR_CYCLES     (3),
        .REPEAT_MASK    (5'b00111)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_n       (key_n),
        .enable      (enable),
        .action      (action),
        .held        (held),
        .state_update(state_update)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [NK-1:0] ea, input logic es, input logic [NK-1:0] eh);
        checks++;
        assert (action === ea) else begin
            errors++;
            $error("FAIL %s action: observed=%b expected=%b", tag, action, ea);
        end
        checks++;
        assert (state_update === es) else begin
            errors++;
            $error("FAIL %s state_update: observed=%b expected=%b", tag, state_update, es);
        end
        checks++;
        assert (held === eh) else begin
            errors++;
            $error("FAIL %s held: observed=%b expected=%b", tag, held, eh);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        enable = 1'b1;
        key_n  = '1;
        #1;
        chk("reset_async", 5'b0, 1'b0, 5'b0);
        tick;
        tick;
        chk("reset_hold", 5'b0, 1'b0, 5'b0);
        rst = 1'b0;
        tick;
        tick;
        chk("idle", 5'b0, 1'b0, 5'b0);

        // Clean press on non-repeating key 3, then release.
        key_n[3] = 1'b0;
        for (int e = 0; e <= 14; e++) begin
            tick;
            chk("press_k3", (e == 6) ? 5'b01000 : 5'b0, (e == 6), (e >= 5) ? 5'b01000 : 5'b0);
        end
        key_n[3] = 1'b1;
        for (int e = 0; e <= 8; e++) begin
            tick;
            chk("release_k3", 5'b0, 1'b0, (e < 5) ? 5'b01000 : 5'b0);
        end

        // Three-cycle glitch on key 0 must be rejected.
        key_n[0] = 1'b0;
        tick;
        tick;
        tick;
        key_n[0] = 1'b1;
        for (int e = 3; e <= 12; e++) begin
            tick;
            chk("glitch_k0", 5'b0, 1'b0, 5'b0);
        end

        // Auto-repeat on key 1: press at 6, repeats at 16, 19, 22, 25, 28; release lands held low at 29.
        key_n[1] = 1'b0;
        for (int e = 0; e <= 40; e++) begin
            tick;
            chk("repeat_k1",
                (e == 6 || e == 16 || e == 19 || e == 22 || e == 25 || e == 28) ? 5'b00010 : 5'b0,
                (e == 6 || e == 16 || e == 19 || e == 22 || e == 25 || e == 28),
                (e >= 5 && e < 29) ? 5'b00010 : 5'b0);
            if (e == 23) key_n[1] = 1'b1;
        end

        // Simultaneous press on keys 0 and 2, released before the first repeat.
        key_n[0] = 1'b0;
        key_n[2] = 1'b0;
        for (int e = 0; e <= 20; e++) begin
            tick;
            chk("simul_k0k2", (e == 6) ? 5'b00101 : 5'b0, (e == 6), (e >= 5 && e < 14) ? 5'b00101 : 5'b0);
            if (e == 8) begin
                key_n[0] = 1'b1;
                key_n[2] = 1'b1;
            end
        end

        // Press dropped while disabled, repeat at 16 once enabled, release due with repeat at 19.
        enable   = 1'b0;
        key_n[0] = 1'b0;
        for (int e = 0; e <= 25; e++) begin
            tick;
            chk("enable_k0", (e == 16) ? 5'b00001 : 5'b0, (e == 16), (e >= 5 && e < 18) ? 5'b00001 : 5'b0);
            if (e == 10) enable = 1'b1;
            if (e == 12) key_n[0] = 1'b1;
        end

        // Reset while key 1 is repeating, then fresh press after reset release.
        key_n[1] = 1'b0;
        for (int e = 0; e <= 16; e++) begin
            tick;
            chk("pre_rst_k1", (e == 6 || e == 16) ? 5'b00010 : 5'b0, (e == 6 || e == 16), (e >= 5) ? 5'b00010 : 5'b0);
        end
        rst = 1'b1;
        #1;
        chk("rst_immediate", 5'b0, 1'b0, 5'b0);
        tick;
        chk("rst_held1", 5'b0, 1'b0, 5'b0);
        tick;
        chk("rst_held2", 5'b0, 1'b0, 5'b0);
        rst = 1'b0;
        for (int e = 0; e <= 10; e++) begin
            tick;
            chk("post_rst_k1", (e == 6) ? 5'b00010 : 5'b0, (e == 6), (e >= 5) ? 5'b00010 : 5'b0);
        end
        key_n[1] = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
